// File: rtl/system86_video_pkg.sv
// ---------------------------------------------------------------------------
// system86_video_pkg
// Shared constants for the tilemap scroll/fetch path: default counter and
// address widths, the CPU register map and the 8-pixel fetch phase slots.
// ---------------------------------------------------------------------------
package system86_video_pkg;

    localparam int HS_W_DEF = 9;   // 512-pixel map
    localparam int VS_W_DEF = 8;   // 256-line map
    localparam int AW_DEF   = 12;  // {layer, v[7:3], h[8:3]}

    // Write-only register map
    localparam logic [2:0] REG_HSA_LO = 3'd0;
    localparam logic [2:0] REG_HSA_HI = 3'd1;
    localparam logic [2:0] REG_VSA    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_HSB_LO = 3'd4;
    localparam logic [2:0] REG_HSB_HI = 3'd5;
    localparam logic [2:0] REG_VSB    = 3'd6;

    // Fetch phase slots within each 8-pixel group
    localparam logic [2:0] PH_ADDR_A = 3'd0;
    localparam logic [2:0] PH_CAP_A  = 3'd1;
    localparam logic [2:0] PH_ADDR_B = 3'd4;
    localparam logic [2:0] PH_CAP_B  = 3'd5;
    localparam logic [2:0] PH_OUT    = 3'd7;

endpackage

// File: rtl/scroll_layer_counter.sv
// ---------------------------------------------------------------------------
// scroll_layer_counter
// One background layer: double-buffered H/V scroll registers, scrolled pixel
// and line counters, and the tilemap row/column of the next tile to fetch.
// Ports:
//   CLK_6M, rst_n          pixel clock, async active-low reset
//   we_hs_lo/we_hs_hi/we_vs write strobes for HS[7:0], HS[8], VS
//   wdata                  CPU write data
//   copy                   shadow -> active transfer (vblank start)
//   flip                   screen flip, inverts row/column/fine
//   nhreset, nvreset       line / frame start (active low)
//   hstart                 first cycle after nhreset returns high
//   row, col               tile row/column the counters reach next cycle,
//                          column already advanced one tile (prefetch)
//   fine                   fine X offset from the active H scroll
// ---------------------------------------------------------------------------
module scroll_layer_counter
    import system86_video_pkg::*;
#(
    parameter int HS_W = HS_W_DEF,
    parameter int VS_W = VS_W_DEF
) (
    input  logic            CLK_6M,
    input  logic            rst_n,
    input  logic            we_hs_lo,
    input  logic            we_hs_hi,
    input  logic            we_vs,
    input  logic [7:0]      wdata,
    input  logic            copy,
    input  logic            flip,
    input  logic            nhreset,
    input  logic            nvreset,
    input  logic            hstart,
    output logic [VS_W-4:0] row,
    output logic [HS_W-4:0] col,
    output logic [2:0]      fine
);

    logic [HS_W-1:0] hs_sh, hs_act, h, h_nxt;
    logic [VS_W-1:0] vs_sh, vs_act, v, v_nxt;

    // Next-cycle counter values: the top issues addresses registered on the
    // edge that enters a phase, so it needs the counters of that phase.
    always_comb begin
        h_nxt = nhreset ? h + HS_W'(1) : hs_act;
        if (!nvreset)
            v_nxt = vs_act;
        else if (hstart)
            v_nxt = v + VS_W'(1);
        else
            v_nxt = v;
        // (h+8)[8:3] is simply h[8:3]+1, wrapping with the map width
        col  = (h_nxt[HS_W-1:3] + (HS_W-3)'(1)) ^ {(HS_W-3){flip}};
        row  = v_nxt[VS_W-1:3] ^ {(VS_W-3){flip}};
        fine = hs_act[2:0] ^ {3{flip}};
    end

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            hs_sh  <= '0;
            hs_act <= '0;
            vs_sh  <= '0;
            vs_act <= '0;
            h      <= '0;
            v      <= '0;
        end else begin
            // Active takes the pre-write shadow when a write coincides with copy
            if (copy) begin
                hs_act <= hs_sh;
                vs_act <= vs_sh;
            end
            if (we_hs_lo) hs_sh[7:0]      <= wdata;
            if (we_hs_hi) hs_sh[HS_W-1:8] <= wdata[HS_W-9:0];
            if (we_vs)    vs_sh           <= wdata[VS_W-1:0];
            h <= h_nxt;
            v <= v_nxt;
        end
    end

endmodule

// File: rtl/cus42_scroll_fetch.sv
// ---------------------------------------------------------------------------
// cus42_scroll_fetch
// Two-layer tilemap scroll/fetch sequencer. Every 8 pixels it reads the next
// tile word for layer A and layer B from tilemap VRAM and presents both with
// a one-cycle TILE_STB.
// Ports:
//   CLK_6M, rst_n             pixel clock, async active-low reset
//   nHRESET/nVRESET/nVBLANK   timing generator line/frame/blank signals
//   CPU_WE, CPU_A, CPU_D      scroll/control register writes
//   VRAM_A, VRAM_D            tilemap read address / data (data next cycle)
//   TILE_A, TILE_B            tile words for layer A / B
//   FINE_A, FINE_B            fine X offsets
//   TILE_STB                  tile outputs updated this cycle
// Build option: CUS42_FLIP_SCREEN_EN adds the CTRL[0] screen-flip bit.
// ---------------------------------------------------------------------------
module cus42_scroll_fetch
    import system86_video_pkg::*;
#(
    parameter int HS_W = HS_W_DEF,
    parameter int VS_W = VS_W_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          CLK_6M,
    input  logic          rst_n,
    input  logic          nHRESET,
    input  logic          nVRESET,
    input  logic          nVBLANK,
    input  logic          CPU_WE,
    input  logic [2:0]    CPU_A,
    input  logic [7:0]    CPU_D,
    output logic [AW-1:0] VRAM_A,
    input  logic [15:0]   VRAM_D,
    output logic [15:0]   TILE_A,
    output logic [15:0]   TILE_B,
    output logic [2:0]    FINE_A,
    output logic [2:0]    FINE_B,
    output logic          TILE_STB
);

    logic [2:0]      phase, phase_nxt;
    logic            nhreset_d, nvblank_d;
    logic            vblank_fall, hstart;
    logic            flip_act;
    logic [15:0]     pend_a, pend_b;
    logic [VS_W-4:0] row_a, row_b;
    logic [HS_W-4:0] col_a, col_b;
    logic [2:0]      fine_a, fine_b;

    assign vblank_fall = nvblank_d & ~nVBLANK;
    assign hstart      = nHRESET & ~nhreset_d;
    // Line start restarts the group, dropping any partial fetch
    assign phase_nxt   = nHRESET ? phase + 3'd1 : 3'd0;

`ifdef CUS42_FLIP_SCREEN_EN
    logic flip_sh;

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            flip_sh  <= 1'b0;
            flip_act <= 1'b0;
        end else begin
            if (vblank_fall)
                flip_act <= flip_sh;
            if (CPU_WE && CPU_A == REG_CTRL)
                flip_sh <= CPU_D[0];
        end
    end
`else
    assign flip_act = 1'b0;
`endif

    scroll_layer_counter #(.HS_W(HS_W), .VS_W(VS_W)) u_layer_a (
        .CLK_6M   (CLK_6M),
        .rst_n    (rst_n),
        .we_hs_lo (CPU_WE && CPU_A == REG_HSA_LO),
        .we_hs_hi (CPU_WE && CPU_A == REG_HSA_HI),
        .we_vs    (CPU_WE && CPU_A == REG_VSA),
        .wdata    (CPU_D),
        .copy     (vblank_fall),
        .flip     (flip_act),
        .nhreset  (nHRESET),
        .nvreset  (nVRESET),
        .hstart   (hstart),
        .row      (row_a),
        .col      (col_a),
        .fine     (fine_a)
    );

    scroll_layer_counter #(.HS_W(HS_W), .VS_W(VS_W)) u_layer_b (
        .CLK_6M   (CLK_6M),
        .rst_n    (rst_n),
        .we_hs_lo (CPU_WE && CPU_A == REG_HSB_LO),
        .we_hs_hi (CPU_WE && CPU_A == REG_HSB_HI),
        .we_vs    (CPU_WE && CPU_A == REG_VSB),
        .wdata    (CPU_D),
        .copy     (vblank_fall),
        .flip     (flip_act),
        .nhreset  (nHRESET),
        .nvreset  (nVRESET),
        .hstart   (hstart),
        .row      (row_b),
        .col      (col_b),
        .fine     (fine_b)
    );

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 3'd0;
            nhreset_d <= 1'b1;
            nvblank_d <= 1'b1;
            VRAM_A    <= '0;
            pend_a    <= '0;
            pend_b    <= '0;
            TILE_A    <= '0;
            TILE_B    <= '0;
            FINE_A    <= '0;
            FINE_B    <= '0;
            TILE_STB  <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            nhreset_d <= nHRESET;
            nvblank_d <= nVBLANK;

            // Address stage: registered on entry to its phase, held otherwise
            if (phase_nxt == PH_ADDR_A)
                VRAM_A <= {1'b0, row_a, col_a};
            else if (phase_nxt == PH_ADDR_B)
                VRAM_A <= {1'b1, row_b, col_b};

            // Capture stage: data answers the address of the previous phase
            if (phase == PH_CAP_A) pend_a <= VRAM_D;
            if (phase == PH_CAP_B) pend_b <= VRAM_D;

            // Output stage: both layers published together in the last phase
            TILE_STB <= (phase_nxt == PH_OUT);
            if (phase_nxt == PH_OUT) begin
                TILE_A <= pend_a;
                TILE_B <= pend_b;
                FINE_A <= fine_a;
                FINE_B <= fine_b;
            end
        end
    end

endmodule
